// File: rtl/multisim_bridge_pkg.sv
// Shared types and width helpers for the command-to-memory bridge that sits
// behind the multisim pull/push server.
package multisim_bridge_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_NOP     = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BUS_ERR = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BAD_OP  = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  function automatic int cmd_width(input int aw, input int dw);
    return 2 + aw + dw;
  endfunction

  function automatic int rsp_width(input int dw);
    return 2 + dw;
  endfunction

endpackage

// File: rtl/multisim_cmd_mem_bridge.sv
// Pulls one command at a time from the server, runs it as a single memory bus
// access and pushes back exactly one status/data response per command.
module multisim_cmd_mem_bridge
  import multisim_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int CMD_WIDTH     = cmd_width(ADDR_WIDTH, DATA_WIDTH),
  localparam int RSP_WIDTH     = rsp_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [CMD_WIDTH-1:0]  cmd_data,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [RSP_WIDTH-1:0]  rsp_data,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_err,
  output logic [15:0]           stale_rsp_cnt
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  state_e                state, state_next;
  logic                  cmd_rdy_next;
  logic                  rsp_vld_next;
  logic [RSP_WIDTH-1:0]  rsp_data_next;
  logic                  mem_req_next;
  logic                  mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_next;
  logic [31:0]           tcnt, tcnt_next;
  logic [1:0]            cmd_op;
  logic                  timeout_hit;

  assign cmd_op = cmd_data[CMD_WIDTH-1 -: 2];
  // Fires on the edge at which the counter would reach TIMEOUT_CYCLES; >= keeps
  // it live in WAIT when a grant beat the timeout on the last REQ cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt >= TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cmd_rdy       <= 1'b0;
      rsp_vld       <= 1'b0;
      rsp_data      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      tcnt          <= '0;
      stale_rsp_cnt <= '0;
    end else begin
      state     <= state_next;
      cmd_rdy   <= cmd_rdy_next;
      rsp_vld   <= rsp_vld_next;
      rsp_data  <= rsp_data_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      tcnt      <= tcnt_next;
      if (mem_rvalid && (state != S_WAIT) && (stale_rsp_cnt != 16'hFFFF))
        stale_rsp_cnt <= stale_rsp_cnt + 16'd1;
    end
  end

  always_comb begin
    state_next     = state;
    rsp_vld_next   = rsp_vld;
    rsp_data_next  = rsp_data;
    mem_req_next   = mem_req;
    mem_we_next    = mem_we;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    tcnt_next      = tcnt;

    case (state)
      S_IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          tcnt_next = '0;
          case (cmd_op)
            OP_READ, OP_WRITE: begin
              state_next     = S_REQ;
              mem_req_next   = 1'b1;
              mem_we_next    = cmd_op[0];
              mem_addr_next  = cmd_data[DATA_WIDTH +: ADDR_WIDTH];
              mem_wdata_next = cmd_data[DATA_WIDTH-1:0];
            end
            OP_NOP: begin
              state_next    = S_RESP;
              rsp_vld_next  = 1'b1;
              rsp_data_next = {ST_OK, ZERO_DATA};
            end
            default: begin
              state_next    = S_RESP;
              rsp_vld_next  = 1'b1;
              rsp_data_next = {ST_BAD_OP, ZERO_DATA};
            end
          endcase
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_next   = S_WAIT;
          mem_req_next = 1'b0;
          tcnt_next    = tcnt + 32'd1;
        end else if (timeout_hit) begin
          state_next    = S_RESP;
          mem_req_next  = 1'b0;
          rsp_vld_next  = 1'b1;
          rsp_data_next = {ST_TIMEOUT, ZERO_DATA};
        end else begin
          tcnt_next = tcnt + 32'd1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_next    = S_RESP;
          rsp_vld_next  = 1'b1;
          rsp_data_next = {(mem_err ? ST_BUS_ERR : ST_OK),
                           ((!mem_we && !mem_err) ? mem_rdata : ZERO_DATA)};
        end else if (timeout_hit) begin
          state_next    = S_RESP;
          rsp_vld_next  = 1'b1;
          rsp_data_next = {ST_TIMEOUT, ZERO_DATA};
        end else begin
          tcnt_next = tcnt + 32'd1;
        end
      end
      S_RESP: begin
        if (rsp_rdy) begin
          state_next   = S_IDLE;
          rsp_vld_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase

    cmd_rdy_next = (state_next == S_IDLE);
  end

endmodule
